// File: rtl/hwag_regfile_pkg.sv
// Shared state type, default geometry and the address-region helper for the HWAG register file.
package hwag_regfile_pkg;
   localparam int DEF_DATA_W      = 16;
   localparam int DEF_ADDR_W      = 8;
   localparam int DEF_DEPTH       = 64;
   localparam int DEF_RO_BASE     = 48;
   localparam int DEF_COMMIT_ADDR = 255;

   typedef enum logic [1:0] {IDLE, WR_WAIT, RD_LOAD, RD_DRIVE} state_t;
   typedef enum logic [1:0] {REGION_RW, REGION_RO, REGION_NONE} region_t;

   function automatic region_t word_region(input int unsigned addr,
                                           input int unsigned ro_base,
                                           input int unsigned depth);
      if (addr < ro_base)    return REGION_RW;
      else if (addr < depth) return REGION_RO;
      else                   return REGION_NONE;
   endfunction
endpackage

// File: rtl/hwag_regfile_if.sv
// Control/address signals of the external bus plus the core's status write port.
interface hwag_regfile_if #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 16
);
   logic              ssram_we;
   logic              ssram_re;
   logic [ADDR_W-1:0] ssram_addr;
   logic              hw_we;
   logic [ADDR_W-1:0] hw_addr;
   logic [DATA_W-1:0] hw_data;

   modport master (output ssram_we, ssram_re, ssram_addr, hw_we, hw_addr, hw_data);
   modport slave  (input  ssram_we, ssram_re, ssram_addr, hw_we, hw_addr, hw_data);
endinterface

// File: rtl/hwag_strobe_sync.sv
// Two-flop synchroniser with history flop and rise/fall detection for one bus strobe.
module hwag_strobe_sync (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic level,
   output logic rise,
   output logic fall
);
   logic [1:0] sync;
   logic       hist;
   logic [1:0] fill;
   logic       armed;

   // Edges are only reported once a real low has come through the synchroniser, so a strobe held high across reset release is not an edge.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync  <= '0;
         hist  <= 1'b0;
         fill  <= '0;
         armed <= 1'b0;
      end else begin
         sync <= {sync[0], din};
         hist <= sync[1];
         fill <= {fill[0], 1'b1};
         if (fill[1] && !sync[1]) armed <= 1'b1;
      end
   end

   assign level = sync[1];
   assign rise  = armed & sync[1] & ~hist;
   assign fall  = armed & ~sync[1] & hist;
endmodule

// File: rtl/hwag_regfile.sv
// Bus-accessible parameter store: double-buffered RW words with atomic commit and a hardware-written status region.
module hwag_regfile
   import hwag_regfile_pkg::*;
#(
   parameter int DATA_W  = DEF_DATA_W,
   parameter int ADDR_W  = DEF_ADDR_W,
   parameter int DEPTH   = DEF_DEPTH,
   parameter int RO_BASE = DEF_RO_BASE,
   parameter logic [ADDR_W-1:0] COMMIT_ADDR = ADDR_W'(DEF_COMMIT_ADDR)
) (
   input  logic                    clk,
   input  logic                    rst,
   hwag_regfile_if.slave           bus,
   inout  wire  [DATA_W-1:0]       ssram_data,
   output logic [DATA_W*DEPTH-1:0] out,
   output logic                    commit_pulse,
   output logic                    err
);
   logic [DATA_W-1:0] shadow [RO_BASE];
   logic [DATA_W-1:0] active [RO_BASE];
   logic [DATA_W-1:0] status [RO_BASE:DEPTH-1];
   logic [DATA_W-1:0] rd_buf, rd_word;
   logic [ADDR_W-1:0] rd_addr;
   logic              commit_req;
   state_t            state, state_next;
   region_t           wr_region;
   logic              shadow_we, commit_set, err_next, rd_load, addr_latch, drive;
   logic              we_level, we_rise, we_fall_unused;
   logic              re_level_unused, re_rise, re_fall;

   hwag_strobe_sync u_we_sync (.clk(clk), .rst(rst), .din(bus.ssram_we),
                               .level(we_level), .rise(we_rise), .fall(we_fall_unused));
   hwag_strobe_sync u_re_sync (.clk(clk), .rst(rst), .din(bus.ssram_re),
                               .level(re_level_unused), .rise(re_rise), .fall(re_fall));

   assign wr_region = word_region(32'(bus.ssram_addr), RO_BASE, DEPTH);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_next;
   end

   // Only IDLE reacts to strobe edges; a simultaneous we/re rise is rejected as ambiguous.
   always_comb begin
      state_next = state;
      shadow_we  = 1'b0;
      commit_set = 1'b0;
      err_next   = 1'b0;
      rd_load    = 1'b0;
      addr_latch = 1'b0;
      unique case (state)
         IDLE: begin
            if (we_rise && re_rise) begin
               err_next = 1'b1;
            end else if (we_rise) begin
               state_next = WR_WAIT;
               if (wr_region == REGION_RW)           shadow_we  = 1'b1;
               else if (bus.ssram_addr == COMMIT_ADDR) commit_set = ssram_data[0];
               else                                   err_next   = 1'b1;
            end else if (re_rise) begin
               addr_latch = 1'b1;
               state_next = RD_LOAD;
            end
         end
         WR_WAIT:  if (!we_level) state_next = IDLE;
         RD_LOAD: begin
            rd_load    = 1'b1;
            state_next = RD_DRIVE;
         end
         RD_DRIVE: if (re_fall) state_next = IDLE;
         default:  state_next = IDLE;
      endcase
   end

   always_comb begin
      rd_word = '0;
      for (int i = 0; i < RO_BASE; i++)
         if (rd_addr == ADDR_W'(i)) rd_word = shadow[i];
      for (int i = RO_BASE; i < DEPTH; i++)
         if (rd_addr == ADDR_W'(i)) rd_word = status[i];
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_addr      <= '0;
         rd_buf       <= '0;
         commit_req   <= 1'b0;
         commit_pulse <= 1'b0;
         err          <= 1'b0;
      end else begin
         if (addr_latch) rd_addr <= bus.ssram_addr;
         if (rd_load)    rd_buf  <= rd_word;
         commit_req   <= commit_set;
         commit_pulse <= commit_req;
         err          <= err_next;
      end
   end

   // Commit copies every shadow word into the active set on the same edge.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < RO_BASE; i++) begin
            shadow[i] <= '0;
            active[i] <= '0;
         end
      end else begin
         for (int i = 0; i < RO_BASE; i++) begin
            if (shadow_we && bus.ssram_addr == ADDR_W'(i)) shadow[i] <= ssram_data;
            if (commit_req) active[i] <= shadow[i];
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = RO_BASE; i < DEPTH; i++) status[i] <= '0;
      end else begin
         for (int i = RO_BASE; i < DEPTH; i++)
            if (bus.hw_we && bus.hw_addr == ADDR_W'(i)) status[i] <= bus.hw_data;
      end
   end

   // The bus is let go in the very cycle the synchronised re fall is seen.
   assign drive      = (state == RD_DRIVE) && !re_fall;
   assign ssram_data = drive ? rd_buf : {DATA_W{1'bz}};

   for (genvar i = 0; i < DEPTH; i++) begin : g_out
      if (i < RO_BASE) begin : g_rw
         assign out[i*DATA_W +: DATA_W] = active[i];
      end else begin : g_ro
         assign out[i*DATA_W +: DATA_W] = status[i];
      end
   end
endmodule

// File: doc/hwag_regfile.md
# hwag_regfile

Parametrised successor to the HWAG's bus-accessible register file. Memory-mapped parameter store between the external 16-bit asynchronous bus (we/re/addr/bidirectional data) and the HWAG core. Adds strobe synchronisation, double-buffered RW words with atomic commit, and a hardware-written read-only status region. Exposes all active words to the core as one flat bus.

## Interface
- DATA_W, 16, word width
- ADDR_W, 8, bus address width
- DEPTH, 64, implemented words (DEPTH ≤ 2**ADDR_W, DEPTH ≤ COMMIT_ADDR)
- RO_BASE, 48, first status word; words RO_BASE..DEPTH-1 read-only from bus
- COMMIT_ADDR, 8'hFF, commit register address
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-low
- ssram_we  in  1  bus write strobe, asynchronous to clk
- ssram_re  in  1  bus read strobe, asynchronous to clk
- ssram_addr  in  ADDR_W  bus address
- ssram_data  inout  DATA_W  bus data; driven only in RD_DRIVE, else 'z
- hw_we  in  1  status write enable (clk domain)
- hw_addr  in  ADDR_W  status word address
- hw_data  in  DATA_W  status write data
- out  out  DATA_W*DEPTH  active words; word i at [i*DATA_W +: DATA_W]
- commit_pulse  out  1  one-cycle pulse when active set updated
- err  out  1  one-cycle pulse on illegal bus access

## Operation
- Storage: shadow[0..RO_BASE-1] (bus-written), active[0..RO_BASE-1] (drives out), status[RO_BASE..DEPTH-1] (hw-written, drives out directly).
- Strobes: each passes 2-flop synchroniser plus history flop; rise/fall = detected edges of synchronised level.
- FSM states IDLE, WR_WAIT, RD_LOAD, RD_DRIVE.
- IDLE, we rise (re not rising): sample addr/data; addr < RO_BASE → shadow write; addr == COMMIT_ADDR and data[0]=1 → commit; data[0]=0 → no-op; any other addr → err pulse, no write. Go WR_WAIT.
- WR_WAIT → IDLE when synchronised we low. Exactly one write per strobe.
- IDLE, re rise (we not rising): latch addr, go RD_LOAD. RD_LOAD: rd_buf ← shadow (addr < RO_BASE), status (RO_BASE ≤ addr < DEPTH), 0 otherwise (incl. COMMIT_ADDR); go RD_DRIVE.
- RD_DRIVE: drive rd_buf; on re fall release bus same cycle, go IDLE.
- we and re rising same cycle in IDLE: err pulse, both ignored, stay IDLE. Edges outside IDLE are ignored.
- Commit: one cycle after commit write, active[i] ← shadow[i] for all i < RO_BASE simultaneously; commit_pulse high that cycle. Shadow write and commit never collide (FSM serialises).
- hw_we with RO_BASE ≤ hw_addr < DEPTH writes status; other hw_addr silently ignored. hw write and RD_LOAD to same word in same cycle: rd_buf gets old value.
- Reset (rst=0, any state, mid-access): shadow, active, status, rd_buf, sync flops = 0; FSM IDLE; bus released immediately; commit_pulse=0, err=0. Strobe held high across reset release is not an edge (history flop resets 0 but synchroniser also 0; first edge seen only after strobe low then high).

## Timing
- Pin edge before clk edge k → synchronised at k+1 → edge detected during cycle k+1..k+2.
- Write: shadow updated at edge k+2; err pulse in cycle after k+2. Commit: active + commit_pulse at edge k+3.
- Read: RD_LOAD at k+2, rd_buf valid and driven after k+3; master samples ≥4 clk after raising re.
- Master holds addr/data stable from strobe rise until ≥3 clk later; minimum strobe low time 3 clk.
- Bus release: ≤3 clk after re falls at pin.

## Structure
- Package hwag_regfile_pkg: FSM state enum, default parameter constants, function for word index range checks.
- Sub-module hwag_strobe_sync (2-flop sync + rise/fall detect), instantiated for we and re.

## Test plan
- Reset: all out words 0, ssram_data 'z, commit_pulse=err=0.
- Write 0x1234 to addr 5, read addr 5 → 0x1234 driven; out word 5 stays 0 until write 0x0001 to 0xFF, then word 5 = 0x1234 with one commit_pulse.
- hw_we addr 50 data 0xBEEF → out word 50 = 0xBEEF next cycle; bus read 50 → 0xBEEF; bus write 50 → err pulse, word unchanged.
- we and re rising same cycle → err pulse, no state change; write to 0xFF with data 0 → no commit_pulse.
- rst asserted in RD_DRIVE → bus 'z immediately, all words 0; re held high through release → no read occurs.
- hw write to addr 60 concurrent with RD_LOAD of 60 → bus returns old value; next read returns new.
